vga_sram_arbiter: RTL and testbench

VGA_SRAM_ARBITER -- requirements
Module: vga_sram_arbiter

---
 rtl/vga_sram_arbiter_if.sv | 38 +++
 rtl/vga_sram_arbiter.sv | 167 ++++++++++++++++
 tb/tb_vga_sram_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_sram_arbiter_if.sv
// Bus bundle for vga_sram_arbiter: pixel read port, CPU write port,
// SRAM pins and the dropped-request statistic.
// slave  = the arbiter side, master = the side that drives requests and SRAM read data.
interface vga_sram_arbiter_if #(
    parameter int ADDR_W = 17
);
    // Pixel read port
    logic              pix_req;
    logic [ADDR_W-1:0] pix_addr;
    logic [7:0]        pix_data;
    logic              pix_valid;
    logic              pix_late;
    // CPU write port
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    // SRAM pins
    logic [ADDR_W-1:0] sram_a;
    logic [7:0]        sram_dq_out;
    logic              sram_dq_oe;
    logic [7:0]        sram_dq_in;
    logic              sram_n_we;
    // Statistics
    logic [15:0]       miss_cnt;

    modport slave (
        input  pix_req, pix_addr, wr_valid, wr_addr, wr_data, sram_dq_in,
        output pix_data, pix_valid, pix_late, wr_ready,
               sram_a, sram_dq_out, sram_dq_oe, sram_n_we, miss_cnt
    );

    modport master (
        output pix_req, pix_addr, wr_valid, wr_addr, wr_data, sram_dq_in,
        input  pix_data, pix_valid, pix_late, wr_ready,
               sram_a, sram_dq_out, sram_dq_oe, sram_n_we, miss_cnt
    );
endinterface

// File: rtl/vga_sram_arbiter.sv
// vga_sram_arbiter: shares one asynchronous byte-wide SRAM between the video
// scan (pixel reads, highest priority) and a CPU write FIFO.
// Reads take one RD cycle; writes are a fixed SETUP/STROBE/HOLD sequence.
// A pixel request arriving during a write is parked in a one-deep pending
// register and served right after WR_HOLD (flagged with pix_late).
// Optional feature macro: VGA_ARB_STATS_EN enables the saturating miss_cnt.
module vga_sram_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 17
) (
    input logic               clk,
    input logic               reset_n,
    vga_sram_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_LVL = FIFO_DEPTH[PTR_W:0];

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] RD        = 3'd1;
    localparam logic [2:0] WR_SETUP  = 3'd2;
    localparam logic [2:0] WR_STROBE = 3'd3;
    localparam logic [2:0] WR_HOLD   = 3'd4;

    logic [2:0]        state;
    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [7:0]        fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    level;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_addr;
    logic              rd_late;

    // Full test uses the registered level, so a pop in the same cycle never frees a slot early.
    assign bus.wr_ready = (level < DEPTH_LVL);
    assign push         = bus.wr_valid && bus.wr_ready;
    // The head leaves the FIFO on entry to WR_HOLD; address/data are already latched on the pins.
    assign pop          = (state == WR_STROBE);
    assign fifo_empty   = (level == '0);

    // FIFO storage: written on accepted offers.
    // NOTE: the storage array has no reset; validity is tracked by level/pointers, which are reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= bus.wr_addr;
            fifo_data[wr_ptr] <= bus.wr_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      level <= level + 1'b1;
            else if (!push && pop) level <= level - 1'b1;
        end
    end

    // Arbitration FSM; every SRAM pin and pixel output comes straight from a register here.
    // NOTE: all state uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            bus.sram_a      <= '0;
            bus.sram_dq_out <= '0;
            bus.sram_dq_oe  <= 1'b0;
            bus.sram_n_we   <= 1'b1;
            bus.pix_data    <= '0;
            bus.pix_valid   <= 1'b0;
            bus.pix_late    <= 1'b0;
            pend_valid      <= 1'b0;
            pend_addr       <= '0;
            rd_late         <= 1'b0;
        end else begin
            bus.pix_valid <= 1'b0;
            bus.pix_late  <= 1'b0;
            if (state == RD) begin
                bus.pix_data  <= bus.sram_dq_in;
                bus.pix_valid <= 1'b1;
                bus.pix_late  <= rd_late;
            end

            case (state)
                IDLE, RD: begin
                    if (bus.pix_req) begin
                        state          <= RD;
                        bus.sram_a     <= bus.pix_addr;
                        bus.sram_dq_oe <= 1'b0;
                        bus.sram_n_we  <= 1'b1;
                        rd_late        <= 1'b0;
                    end else if (!fifo_empty) begin
                        state           <= WR_SETUP;
                        bus.sram_a      <= fifo_addr[rd_ptr];
                        bus.sram_dq_out <= fifo_data[rd_ptr];
                        bus.sram_dq_oe  <= 1'b1;
                        bus.sram_n_we   <= 1'b1;
                    end else begin
                        state          <= IDLE;
                        bus.sram_dq_oe <= 1'b0;
                        bus.sram_n_we  <= 1'b1;
                    end
                end
                WR_SETUP, WR_STROBE: begin
                    state         <= (state == WR_SETUP) ? WR_STROBE : WR_HOLD;
                    bus.sram_n_we <= (state == WR_SETUP) ? 1'b0 : 1'b1;
                    // Park one pixel request; a second one is dropped.
                    if (bus.pix_req && !pend_valid) begin
                        pend_valid <= 1'b1;
                        pend_addr  <= bus.pix_addr;
                    end
                end
                WR_HOLD: begin
                    if (pend_valid) begin
                        // Parked request goes ahead of any queued write; a new request this cycle is dropped.
                        state          <= RD;
                        bus.sram_a     <= pend_addr;
                        bus.sram_dq_oe <= 1'b0;
                        rd_late        <= 1'b1;
                        pend_valid     <= 1'b0;
                    end else if (bus.pix_req) begin
                        // Arrives with the write already finishing, so it sees normal latency.
                        state          <= RD;
                        bus.sram_a     <= bus.pix_addr;
                        bus.sram_dq_oe <= 1'b0;
                        rd_late        <= 1'b0;
                    end else begin
                        state          <= IDLE;
                        bus.sram_dq_oe <= 1'b0;
                    end
                    bus.sram_n_we <= 1'b1;
                end
                default: begin
                    state          <= IDLE;
                    bus.sram_dq_oe <= 1'b0;
                    bus.sram_n_we  <= 1'b1;
                end
            endcase
        end
    end

`ifdef VGA_ARB_STATS_EN
    logic        miss;
    logic [15:0] miss_cnt_q;

    assign miss = bus.pix_req && pend_valid &&
                  ((state == WR_SETUP) || (state == WR_STROBE) || (state == WR_HOLD));

    // Saturating count of pixel requests dropped because the pending slot was occupied.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                           miss_cnt_q <= '0;
        else if (miss && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
    end

    assign bus.miss_cnt = miss_cnt_q;
`else
    assign bus.miss_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_sram_arbiter.sv
// Self-checking bench for vga_sram_arbiter (FIFO_DEPTH=4, ADDR_W=17).
// Honours VGA_ARB_STATS_EN for the expected miss_cnt value.
module tb_vga_sram_arbiter;
    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    vga_sram_arbiter_if #(.ADDR_W(17)) bus ();

    vga_sram_arbiter #(.FIFO_DEPTH(4), .ADDR_W(17)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        pix_req;
        logic [16:0] pix_addr;
        logic        wr_valid;
        logic [16:0] wr_addr;
        logic [7:0]  wr_data;
        logic [7:0]  dq_in;
        logic [16:0] e_a;
        logic [7:0]  e_dq;
        logic        e_oe;
        logic        e_nwe;
        logic        e_pv;
        logic [7:0]  e_pd;
        logic        e_pl;
        logic        e_rdy;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock and settle just after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [16:0] exp_a  [4];
    logic [7:0]  exp_d  [4];
    logic [16:0] got_a  [$];
    logic [7:0]  got_d  [$];
    logic [15:0] exp_miss;

    initial begin
        checks   = 0;
        failures = 0;
`ifdef VGA_ARB_STATS_EN
        exp_miss = 16'd1;
`else
        exp_miss = 16'd0;
`endif
        //              req addr      wv waddr     wd     dqin  | a          dq     oe nwe pv pd    pl rdy
        vecs[0]  = '{1'b1, 17'h00100, 1'b0, 17'h0, 8'h00, 8'h00, 17'h00100, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 17'h00000, 1'b0, 17'h0, 8'h00, 8'hA5, 17'h00100, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 17'h00000, 1'b0, 17'h0, 8'h00, 8'h00, 17'h00100, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 17'h00000, 1'b1, 17'h00010, 8'h11, 8'h00, 17'h00100, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 17'h00000, 1'b1, 17'h00011, 8'h22, 8'h00, 17'h00010, 8'h11, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 17'h00000, 1'b1, 17'h00012, 8'h33, 8'h00, 17'h00010, 8'h11, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 17'h00000, 1'b0, 17'h0, 8'h00, 8'h00, 17'h00010, 8'h11, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 17'h00000, 1'b0, 17'h0, 8'h00, 8'h00, 17'h00010, 8'h11, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 17'h00000, 1'b0, 17'h0, 8'h00, 8'h00, 17'h00011, 8'h22, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 17'h00000, 1'b0, 17'h0, 8'h00, 8'h00, 17'h00011, 8'h22, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 17'h00000, 1'b0, 17'h0, 8'h00, 8'h00, 17'h00011, 8'h22, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 17'h00000, 1'b0, 17'h0, 8'h00, 8'h00, 17'h00011, 8'h22, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 17'h00000, 1'b0, 17'h0, 8'h00, 8'h00, 17'h00012, 8'h33, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 17'h00000, 1'b0, 17'h0, 8'h00, 8'h00, 17'h00012, 8'h33, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 17'h00000, 1'b0, 17'h0, 8'h00, 8'h00, 17'h00012, 8'h33, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 17'h00000, 1'b0, 17'h0, 8'h00, 8'h00, 17'h00012, 8'h33, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 17'h00000, 1'b0, 17'h0, 8'h00, 8'h00, 17'h00012, 8'h33, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1};

        // Reset state
        reset_n        = 1'b0;
        bus.pix_req    = 1'b0;
        bus.pix_addr   = '0;
        bus.wr_valid   = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.sram_dq_in = '0;
        tick();
        tick();
        check("rst_sram_a", 32'(bus.sram_a), 32'h0);
        check("rst_dq_out", 32'(bus.sram_dq_out), 32'h0);
        check("rst_dq_oe", 32'(bus.sram_dq_oe), 32'h0);
        check("rst_n_we", 32'(bus.sram_n_we), 32'h1);
        check("rst_pix_data", 32'(bus.pix_data), 32'h0);
        check("rst_pix_valid", 32'(bus.pix_valid), 32'h0);
        check("rst_pix_late", 32'(bus.pix_late), 32'h0);
        check("rst_miss_cnt", 32'(bus.miss_cnt), 32'h0);
        check("rst_wr_ready", 32'(bus.wr_ready), 32'h1);
        reset_n = 1'b1;

        // Table: basic read with 2-cycle latency, then three queued writes drained in order.
        for (int i = 0; i < 17; i++) begin
            bus.pix_req    = vecs[i].pix_req;
            bus.pix_addr   = vecs[i].pix_addr;
            bus.wr_valid   = vecs[i].wr_valid;
            bus.wr_addr    = vecs[i].wr_addr;
            bus.wr_data    = vecs[i].wr_data;
            bus.sram_dq_in = vecs[i].dq_in;
            tick();
            check($sformatf("v%0d_sram_a", i), 32'(bus.sram_a), 32'(vecs[i].e_a));
            check($sformatf("v%0d_dq_out", i), 32'(bus.sram_dq_out), 32'(vecs[i].e_dq));
            check($sformatf("v%0d_dq_oe", i), 32'(bus.sram_dq_oe), 32'(vecs[i].e_oe));
            check($sformatf("v%0d_n_we", i), 32'(bus.sram_n_we), 32'(vecs[i].e_nwe));
            check($sformatf("v%0d_pix_valid", i), 32'(bus.pix_valid), 32'(vecs[i].e_pv));
            check($sformatf("v%0d_pix_data", i), 32'(bus.pix_data), 32'(vecs[i].e_pd));
            check($sformatf("v%0d_pix_late", i), 32'(bus.pix_late), 32'(vecs[i].e_pl));
            check($sformatf("v%0d_wr_ready", i), 32'(bus.wr_ready), 32'(vecs[i].e_rdy));
        end

        // Fill the FIFO while reads are held continuously; nothing may drain.
        bus.pix_req    = 1'b1;
        bus.pix_addr   = 17'h00200;
        bus.sram_dq_in = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            exp_a[i]     = 17'h00020 + 17'(i);
            exp_d[i]     = 8'hA0 + 8'(i);
            bus.wr_valid = 1'b1;
            bus.wr_addr  = exp_a[i];
            bus.wr_data  = exp_d[i];
            tick();
            check($sformatf("fill%0d_wr_ready", i), 32'(bus.wr_ready), (i < 3) ? 32'h1 : 32'h0);
            check($sformatf("fill%0d_dq_oe", i), 32'(bus.sram_dq_oe), 32'h0);
            if (i > 0) check($sformatf("fill%0d_pix_valid", i), 32'(bus.pix_valid), 32'h1);
        end
        bus.wr_addr = 17'h0002F;
        bus.wr_data = 8'hEE;
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("full%0d_wr_ready", i), 32'(bus.wr_ready), 32'h0);
            check($sformatf("full%0d_n_we", i), 32'(bus.sram_n_we), 32'h1);
            check($sformatf("full%0d_dq_oe", i), 32'(bus.sram_dq_oe), 32'h0);
            check($sformatf("full%0d_pix_data", i), 32'(bus.pix_data), 32'h5A);
        end
        bus.pix_req  = 1'b0;
        bus.wr_valid = 1'b0;
        got_a.delete();
        got_d.delete();
        for (int c = 0; c < 25; c++) begin
            tick();
            if (bus.sram_n_we == 1'b0) begin
                got_a.push_back(bus.sram_a);
                got_d.push_back(bus.sram_dq_out);
            end
        end
        check("drain_count", 32'(got_a.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < got_a.size()) begin
                check($sformatf("drain%0d_addr", i), 32'(got_a[i]), 32'(exp_a[i]));
                check($sformatf("drain%0d_data", i), 32'(got_d[i]), 32'(exp_d[i]));
            end
        end
        check("drain_wr_ready", 32'(bus.wr_ready), 32'h1);
        check("drain_dq_oe", 32'(bus.sram_dq_oe), 32'h0);

        // Pixel request during a write is parked; a second one is dropped.
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 17'h00040;
        bus.wr_data  = 8'h77;
        tick();
        bus.wr_valid = 1'b0;
        tick();
        check("pend_setup_oe", 32'(bus.sram_dq_oe), 32'h1);
        check("pend_setup_a", 32'(bus.sram_a), 32'h00040);
        bus.pix_req  = 1'b1;
        bus.pix_addr = 17'h00300;
        tick();
        check("pend_strobe_n_we", 32'(bus.sram_n_we), 32'h0);
        bus.pix_addr = 17'h00301;
        tick();
        check("pend_hold_n_we", 32'(bus.sram_n_we), 32'h1);
        check("pend_hold_a", 32'(bus.sram_a), 32'h00040);
        check("pend_hold_dq", 32'(bus.sram_dq_out), 32'h77);
        bus.pix_req = 1'b0;
        tick();
        check("pend_rd_a", 32'(bus.sram_a), 32'h00300);
        check("pend_rd_oe", 32'(bus.sram_dq_oe), 32'h0);
        bus.sram_dq_in = 8'hC3;
        tick();
        check("pend_pix_valid", 32'(bus.pix_valid), 32'h1);
        check("pend_pix_data", 32'(bus.pix_data), 32'hC3);
        check("pend_pix_late", 32'(bus.pix_late), 32'h1);
        check("miss_cnt", 32'(bus.miss_cnt), 32'(exp_miss));
        bus.sram_dq_in = 8'h00;
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("drop%0d_pix_valid", c), 32'(bus.pix_valid), 32'h0);
            check($sformatf("drop%0d_sram_a", c), 32'(bus.sram_a), 32'h00300);
        end

        // Asynchronous reset in the middle of a write strobe.
        for (int i = 0; i < 3; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr  = 17'h00050 + 17'(i);
            bus.wr_data  = 8'h60 + 8'(i);
            tick();
        end
        check("arst_pre_n_we", 32'(bus.sram_n_we), 32'h0);
        bus.wr_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_n_we", 32'(bus.sram_n_we), 32'h1);
        check("arst_dq_oe", 32'(bus.sram_dq_oe), 32'h0);
        check("arst_sram_a", 32'(bus.sram_a), 32'h0);
        tick();
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            check($sformatf("post%0d_wr_ready", c), 32'(bus.wr_ready), 32'h1);
            check($sformatf("post%0d_dq_oe", c), 32'(bus.sram_dq_oe), 32'h0);
            check($sformatf("post%0d_n_we", c), 32'(bus.sram_n_we), 32'h1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
